// File: rtl/bram_burst_sp.sv
// bram_burst_sp: single-port block RAM behind a simple burst command port.
//
// A command (cmd_valid/cmd_ready) starts a burst of cmd_len+1 beats at
// cmd_addr.  Write bursts take one beat per wr_valid/wr_ready handshake and
// may stall.  Read bursts issue one RAM read per cycle and never stall.
// Addresses wrap modulo DEPTH.
//
// Handshake rule used on every channel: a transfer happens on a rising edge
// where both valid and ready are high.  valid may be raised at any time and
// is not withdrawn by the design; ready never depends on valid in the same
// cycle.  rd_valid has no ready and must be consumed when it appears.
//
// Build option: define BRAM_BURST_OUT_REG_EN to add a reset output register
// after the RAM (read latency 2 instead of 1, rd_data cleared by reset).
//
// dbg_state exposes the FSM state for checkers (0 idle, 1 write, 2 read).
module bram_burst_sp #(
   parameter int WIDTH      = 16,
   parameter int ADDR_WIDTH = 16,
   parameter int LEN_WIDTH  = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [LEN_WIDTH-1:0]  cmd_len,
   input  logic [WIDTH-1:0]      wr_data,
   input  logic                  wr_valid,
   output logic                  wr_ready,
   output logic [WIDTH-1:0]      rd_data,
   output logic                  rd_valid,
   output logic                  rd_last,
   output logic                  busy,
   output logic [1:0]            dbg_state
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_WRITE = 2'd1;
   localparam logic [1:0] ST_READ  = 2'd2;

   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [LEN_WIDTH-1:0]  LEN_ONE  = {{(LEN_WIDTH-1){1'b0}}, 1'b1};

   // Control state
   logic [1:0]            state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [LEN_WIDTH-1:0]  count_q, count_d;
   logic                  cmd_ready_q, cmd_ready_d;

   // Per-cycle events
   logic                  accept;
   logic                  wr_fire;
   logic                  rd_issue;
   logic                  last_beat;

   // RAM and first read stage
   logic [WIDTH-1:0]      mem [DEPTH];
   logic [WIDTH-1:0]      ram_rd_q;
   logic                  rd_valid1_q, rd_valid1_d;
   logic                  rd_last1_q, rd_last1_d;

   // Decode which transfer, if any, happens at the coming edge
   always_comb begin
      accept    = (state_q == ST_IDLE) && cmd_valid && cmd_ready_q;
      wr_fire   = (state_q == ST_WRITE) && wr_valid;
      rd_issue  = (state_q == ST_READ);
      last_beat = (count_q == '0);
   end

   // Next-state logic: latch the command, then walk addr/count one beat at a time
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      count_d = count_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               addr_d  = cmd_addr;
               count_d = cmd_len;
               state_d = cmd_write ? ST_WRITE : ST_READ;
            end
         end
         ST_WRITE: begin
            // wr_valid low simply holds addr and count
            if (wr_fire) begin
               addr_d = addr_q + ADDR_ONE;
               if (last_beat) begin
                  state_d = ST_IDLE;
               end else begin
                  count_d = count_q - LEN_ONE;
               end
            end
         end
         ST_READ: begin
            addr_d = addr_q + ADDR_ONE;
            if (last_beat) begin
               state_d = ST_IDLE;
            end else begin
               count_d = count_q - LEN_ONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      // Ready is registered: high in the cycle after the burst's final beat,
      // so it can never rise while a burst is still in progress.
      cmd_ready_d = (state_d == ST_IDLE);
   end

   // Flags that travel alongside the RAM read data
   always_comb begin
      rd_valid1_d = rd_issue;
      rd_last1_d  = rd_issue && last_beat;
   end

   // Control registers; reset aborts any burst in progress
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         addr_q      <= '0;
         count_q     <= '0;
         cmd_ready_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         count_q     <= count_d;
         cmd_ready_q <= cmd_ready_d;
      end
   end

   // Read-valid pipeline stage one; reset drops reads still in flight
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_valid1_q <= 1'b0;
         rd_last1_q  <= 1'b0;
      end else begin
         rd_valid1_q <= rd_valid1_d;
         rd_last1_q  <= rd_last1_d;
      end
   end

   // Block RAM: no reset so contents survive reset; write port and registered read
   always_ff @(posedge clk) begin
      if (wr_fire) begin
         mem[addr_q] <= wr_data;
      end
      if (rd_issue) begin
         ram_rd_q <= mem[addr_q];
      end
   end

`ifdef BRAM_BURST_OUT_REG_EN
   logic [WIDTH-1:0] rd_data_q, rd_data_d;
   logic             rd_valid2_q, rd_valid2_d;
   logic             rd_last2_q, rd_last2_d;

   // Output register stage inputs
   always_comb begin
      rd_data_d   = ram_rd_q;
      rd_valid2_d = rd_valid1_q;
      rd_last2_d  = rd_last1_q;
   end

   // Output register after the RAM, fully reset
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_data_q   <= '0;
         rd_valid2_q <= 1'b0;
         rd_last2_q  <= 1'b0;
      end else begin
         rd_data_q   <= rd_data_d;
         rd_valid2_q <= rd_valid2_d;
         rd_last2_q  <= rd_last2_d;
      end
   end

   assign rd_data  = rd_data_q;
   assign rd_valid = rd_valid2_q;
   assign rd_last  = rd_last2_q;
`else
   // Data straight from the RAM read register
   assign rd_data  = ram_rd_q;
   assign rd_valid = rd_valid1_q;
   assign rd_last  = rd_last1_q;
`endif

   assign cmd_ready = cmd_ready_q;
   assign wr_ready  = (state_q == ST_WRITE);
   assign busy      = (state_q != ST_IDLE);
   assign dbg_state = state_q;

endmodule

// File: tb/tb_bram_burst_sp.sv
// tb_bram_burst_sp: directed and random bursts against a word-array model.
// Read beats are predicted (data, last flag, arrival cycle) when a read
// command is accepted and retired by a monitor as rd_valid appears.
module tb_bram_burst_sp;

   localparam int W  = 16;
   localparam int AW = 16;
   localparam int LW = 8;
`ifdef BRAM_BURST_OUT_REG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic          cmd_write = 1'b0;
   logic [AW-1:0] cmd_addr = '0;
   logic [LW-1:0] cmd_len = '0;
   logic [W-1:0]  wr_data = '0;
   logic          wr_valid = 1'b0;
   logic          wr_ready;
   logic [W-1:0]  rd_data;
   logic          rd_valid;
   logic          rd_last;
   logic          busy;
   logic [1:0]    dbg_state;

   int tests = 0;
   int fails = 0;
   int cyc = 0;

   // Reference memory and expected read beats
   logic [W-1:0] mdl [0:65535];
   logic [W-1:0] exp_q[$];
   logic         exp_last_q[$];
   int           exp_cyc_q[$];

   bram_burst_sp #(.WIDTH(W), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
      .clk       (clk),
      .reset     (reset),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_write (cmd_write),
      .cmd_addr  (cmd_addr),
      .cmd_len   (cmd_len),
      .wr_data   (wr_data),
      .wr_valid  (wr_valid),
      .wr_ready  (wr_ready),
      .rd_data   (rd_data),
      .rd_valid  (rd_valid),
      .rd_last   (rd_last),
      .busy      (busy),
      .dbg_state (dbg_state)
   );

   // Clock and cycle counter
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Scoreboard monitor: retire predicted read beats one sample after each edge
   always @(posedge clk) begin
      cyc++;
      #1;
      if (reset === 1'b0) begin
         if (rd_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
               check("rd_valid_unexpected", rd_valid, 0);
            end else begin
               check("rd_data", rd_data, exp_q.pop_front());
               check("rd_last", rd_last, exp_last_q.pop_front());
               check("rd_latency", cyc, exp_cyc_q.pop_front());
            end
         end else if (exp_q.size() != 0 && exp_cyc_q[0] <= cyc) begin
            check("rd_valid_missing", rd_valid, 1);
            void'(exp_q.pop_front());
            void'(exp_last_q.pop_front());
            void'(exp_cyc_q.pop_front());
         end
      end
   end

   // Offer a command, wait (bounded) for acceptance; reads predict their beats
   task automatic send_cmd(input logic wr, input logic [AW-1:0] a, input logic [LW-1:0] len,
                           output int acc);
      int guard;
      logic [AW-1:0] ra;
      guard = 0;
      cmd_valid = 1'b1;
      cmd_write = wr;
      cmd_addr  = a;
      cmd_len   = len;
      while (cmd_ready !== 1'b1 && guard < 200) begin
         @(posedge clk); #1;
         guard++;
      end
      check("cmd_accept_timeout", guard < 200, 1);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      acc = cyc;
      if (!wr) begin
         ra = a;
         for (int i = 0; i <= int'(len); i++) begin
            exp_q.push_back(mdl[ra]);
            exp_last_q.push_back(i == int'(len));
            exp_cyc_q.push_back(acc + LAT + i);
            ra = ra + 1'b1;
         end
      end
   endtask

   // Write burst with optional stall before one beat or random stalls
   task automatic do_write(input logic [AW-1:0] a, input logic [LW-1:0] len,
                           input logic [W-1:0] base, input bit rand_data,
                           input int gap_beat, input int gap_len, input bit rand_gap,
                           output int acc);
      int busy_cnt, gaps, g;
      logic [AW-1:0] ad;
      logic [W-1:0] d;
      send_cmd(1'b1, a, len, acc);
      busy_cnt = 0;
      gaps = 0;
      ad = a;
      for (int i = 0; i <= int'(len); i++) begin
         g = (i == gap_beat) ? gap_len : 0;
         if (rand_gap) g = $urandom_range(0, 2);
         gaps += g;
         for (int k = 0; k < g; k++) begin
            wr_valid = 1'b0;
            check("wr_ready_stall", wr_ready, 1);
            if (busy === 1'b1) busy_cnt++;
            @(posedge clk); #1;
         end
         d = rand_data ? W'($urandom) : base + W'(i);
         wr_valid = 1'b1;
         wr_data  = d;
         check("wr_ready", wr_ready, 1);
         if (busy === 1'b1) busy_cnt++;
         @(posedge clk); #1;
         mdl[ad] = d;
         ad = ad + 1'b1;
      end
      wr_valid = 1'b0;
      check("write_busy_cycles", busy_cnt, int'(len) + 1 + gaps);
      check("write_done_busy", busy, 0);
      check("write_done_cmd_ready", cmd_ready, 1);
      check("write_done_wr_ready", wr_ready, 0);
   endtask

   // Read burst: check control outputs per issue cycle, then drain the scoreboard
   task automatic do_read(input logic [AW-1:0] a, input logic [LW-1:0] len);
      int acc, guard;
      send_cmd(1'b0, a, len, acc);
      for (int i = 0; i <= int'(len); i++) begin
         check("read_busy", busy, 1);
         check("read_cmd_ready", cmd_ready, 0);
         check("read_wr_ready", wr_ready, 0);
         @(posedge clk); #1;
      end
      check("read_done_busy", busy, 0);
      check("read_done_cmd_ready", cmd_ready, 1);
      guard = 0;
      while (exp_q.size() != 0 && guard < 20) begin
         @(posedge clk); #1;
         guard++;
      end
      check("read_drain_timeout", guard < 20, 1);
   endtask

   // Directed sequence followed by random bursts
   initial begin
      int acc, acc_r, acc_w;
      logic [AW-1:0] ra;
      logic [LW-1:0] rl;

      // Reset values
      repeat (3) @(posedge clk);
      #1;
      check("reset_cmd_ready", cmd_ready, 0);
      check("reset_busy", busy, 0);
      check("reset_rd_valid", rd_valid, 0);
      check("reset_rd_last", rd_last, 0);
      check("reset_wr_ready", wr_ready, 0);
      check("reset_state", dbg_state, 0);
`ifdef BRAM_BURST_OUT_REG_EN
      check("reset_rd_data", rd_data, 0);
`endif
      #1;
      reset = 1'b0;
      #1;
      check("release_cmd_ready_low", cmd_ready, 0);
      @(posedge clk); #1;
      check("release_cmd_ready_high", cmd_ready, 1);

      // Continuous write burst then read it back
      do_write(16'h0010, 8'd3, 16'hA000, 1'b0, -1, 0, 1'b0, acc);
      do_read(16'h0010, 8'd3);

      // Address wrap at the top of memory
      do_write(16'hFFFE, 8'd3, 16'h0001, 1'b0, -1, 0, 1'b0, acc);
      do_read(16'hFFFE, 8'd3);
      do_read(16'h0000, 8'd1);

      // Stalled write: three idle cycles before beat index 1, neighbour untouched
      do_write(16'h0100, 8'd3, 16'h5550, 1'b0, -1, 0, 1'b0, acc);
      do_write(16'h0100, 8'd2, 16'hB000, 1'b0, 1, 3, 1'b0, acc);
      do_read(16'h0100, 8'd3);

      // Reset in the middle of a read burst
      do_write(16'h0200, 8'd7, 16'hC000, 1'b0, -1, 0, 1'b0, acc);
      send_cmd(1'b0, 16'h0200, 8'd7, acc);
      @(posedge clk);
      @(posedge clk);
      #2;
      reset = 1'b1;
      exp_q.delete();
      exp_last_q.delete();
      exp_cyc_q.delete();
      #1;
      check("midreset_rd_valid", rd_valid, 0);
      check("midreset_rd_last", rd_last, 0);
      check("midreset_busy", busy, 0);
      check("midreset_cmd_ready", cmd_ready, 0);
      check("midreset_wr_ready", wr_ready, 0);
`ifdef BRAM_BURST_OUT_REG_EN
      check("midreset_rd_data", rd_data, 0);
`endif
      @(posedge clk);
      @(posedge clk);
      #2;
      reset = 1'b0;
      #1;
      check("midrelease_cmd_ready_low", cmd_ready, 0);
      @(posedge clk); #1;
      check("midrelease_cmd_ready_high", cmd_ready, 1);
      check("midrelease_rd_valid", rd_valid, 0);
      do_read(16'h0200, 8'd7);
      do_read(16'h0010, 8'd3);

      // Single-beat read with a write command offered back-to-back
      send_cmd(1'b0, 16'h0012, 8'd0, acc_r);
      do_write(16'h0300, 8'd1, 16'hD000, 1'b0, -1, 0, 1'b0, acc_w);
      check("b2b_write_accept_cycle", acc_w, acc_r + 2);
      check("b2b_read_delivered", exp_q.size(), 0);
      do_read(16'h0300, 8'd1);

      // Random bursts with random data and stalls
      for (int n = 0; n < 12; n++) begin
         ra = AW'($urandom_range(0, 65535));
         rl = LW'($urandom_range(0, 15));
         do_write(ra, rl, '0, 1'b1, -1, 0, 1'b1, acc);
         do_read(ra, rl);
         if (rl > 1) do_read(ra + 1'b1, rl - 8'd1);
      end

      // Longest burst length wraps count through the full range
      do_write(16'h8000, 8'hFF, 16'h1000, 1'b0, -1, 0, 1'b0, acc);
      do_read(16'h8000, 8'hFF);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
